alu4_cmd_driver: RTL
====================

// Module: alu4_cmd_driver
// PURPOSE
//  Initiator side of the 4-bit ALU datapath. Queues (a, b, op) commands from an upstream
//  valid/ready port and drives them one at a time into an external combinational
//  alu_4bit. Registers that ALU's result and carry, then returns them on a valid/ready
//  response port. Sits between the sequencer/control logic and the ALU.
// PARAMETERS
//  DEPTH    4    command FIFO entries; power of two, >= 2
//  CNT_W    3    width of fifo_count; must equal $clog2(DEPTH)+1
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      FIFO can accept a command
//  cmd_a        in   4      operand A
//  cmd_b        in   4      operand B
//  cmd_op       in   2      00:ADD 01:SUB 10:AND 11:OR
//  alu_a        out  4      registered operand A to ALU
//  alu_b        out  4      registered operand B to ALU
//  alu_op       out  2      registered op to ALU
//  alu_result   in   4      ALU combinational result
//  alu_cout     in   1      ALU carry out
//  rsp_valid    out  1      response available
//  rsp_ready    in   1      response consumer ready
//  rsp_result   out  4      captured result
//  rsp_cout     out  1      captured carry
//  busy         out  1      state != IDLE or FIFO non-empty
//  fifo_count   out  CNT_W  commands queued (0..DEPTH), excluding the one in flight
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, state IDLE, all outputs 0,
//    cmd_ready=1 once reset is released.
//  - Command push on (cmd_valid & cmd_ready). cmd_ready = (fifo_count != DEPTH), using the
//    registered count. No push when full, even if a pop happens in the same cycle.
//  - FSM states: IDLE, ISSUE, RESP.
//    IDLE : if FIFO non-empty -> pop head into alu_a/alu_b/alu_op, go to ISSUE.
//    ISSUE: exactly 1 cycle; ALU settles. At the end edge: rsp_result<=alu_result,
//           rsp_cout<=alu_cout, rsp_valid<=1, go to RESP.
//    RESP : hold rsp_* stable while rsp_valid & !rsp_ready. On handshake: rsp_valid<=0;
//           if FIFO non-empty, pop and load alu_* on the same edge and go to ISSUE;
//           otherwise go to IDLE.
//  - Latency: command accepted at edge E0 -> alu_* loaded at E1 -> rsp_valid=1 after E2.
//    Throughput: 1 command per 2 cycles when rsp_ready is held high.
//  - alu_* hold their last value outside loads; the ALU is never re-driven mid-ISSUE.
//  - Simultaneous push and pop: fifo_count is unchanged; FIFO order is strictly preserved.
//  - FIFO pointers wrap modulo DEPTH; count saturates by construction at DEPTH.
//  - With the FIFO full and a response stalled, the block holds indefinitely. No drop,
//    no overwrite.
//  - The block does no arithmetic of its own: a SUB result and carry are exactly what
//    the ALU returns (cout=1 means no borrow).
//  - rst_n asserted mid-operation: queued and in-flight commands are discarded and
//    rsp_valid drops to 0 immediately.
// CONFIGURATION
//  ALU4_ZERO_FLAG_EN defined: adds output port rsp_zero (out, 1), registered together
//    with rsp_result as (alu_result == 4'h0). It is 0 in reset and held with rsp_valid.
//  Undefined: no rsp_zero port and no zero-detect logic.
// TESTING (bench instantiates alu_4bit on the alu_* ports)
//  1. Reset: rst_n=0 mid-run -> rsp_valid=0, fifo_count=0, alu_*=0 while low; cmd_ready=1
//     once released.
//  2. ADD a=9 b=8, rsp_ready=1 -> rsp_result=1, rsp_cout=1; rsp_valid rises 2 cycles
//     after acceptance.
//  3. SUB 5-3 -> result 2, cout 1. SUB 3-5 -> result 4'hE, cout 0. AND C,A -> 8.
//     OR C,3 -> F. Responses come back in issue order.
//  4. Backpressure: rsp_ready=0, push continuously. Exactly DEPTH+1=5 commands are
//     accepted, then cmd_ready=0 with fifo_count=4. Release rsp_ready: all 5 responses
//     arrive in order and none are lost.
//  5. Simultaneous push with a pop at fifo_count=2 -> count stays 2; a push at
//     count=DEPTH with a pop in the same cycle is refused (cmd_ready=0).
//  6. ALU4_ZERO_FLAG_EN: SUB 7-7 -> rsp_result=0, rsp_zero=1, rsp_cout=1;
//     ADD 1+1 -> rsp_zero=0.

Source files
------------

// File: rtl/alu4_cmd_driver.sv
// Command FIFO feeding an external combinational 4-bit ALU one command at a time, with a
// registered valid/ready response port. Define ALU4_ZERO_FLAG_EN to add the rsp_zero output.
module alu4_cmd_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_cout,
`ifdef ALU4_ZERO_FLAG_EN
    output logic             rsp_zero,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic [9:0]       mem_q [DEPTH];
    logic [9:0]       head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, fifo_empty;
    logic             capture_rsp, clear_rsp;
    logic [3:0]       alu_a_q, alu_b_q;
    logic [1:0]       alu_op_q;
    logic             rsp_valid_q, rsp_cout_q;
    logic [3:0]       rsp_result_q;

    assign fifo_empty = (count_q == '0);
    // Registered count only: a pop in the same cycle never frees a slot for a push.
    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign head       = mem_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  if (rsp_ready) state_d = fifo_empty ? StIdle : StIssue;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        pop         = 1'b0;
        capture_rsp = 1'b0;
        clear_rsp   = 1'b0;
        unique case (state_q)
            StIdle:  pop = !fifo_empty;
            StIssue: capture_rsp = 1'b1;
            StResp: begin
                clear_rsp = rsp_ready;
                pop       = rsp_ready & !fifo_empty;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else if (pop) begin
            alu_op_q <= head[9:8];
            alu_a_q  <= head[7:4];
            alu_b_q  <= head[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
        end else if (capture_rsp) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_cout_q   <= alu_cout;
        end else if (clear_rsp) begin
            rsp_valid_q  <= 1'b0;
        end
    end

`ifdef ALU4_ZERO_FLAG_EN
    logic rsp_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero_q <= 1'b0;
        end else if (capture_rsp) begin
            rsp_zero_q <= (alu_result == 4'h0);
        end
    end

    assign rsp_zero = rsp_zero_q;
`endif

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign fifo_count = count_q;

endmodule
